// File: rtl/edge_area_unit.sv
// edge_area_unit
//   Multi-cycle triangle edge cross-product unit for the rasterizer setup path.
//   Computes ((v1x-v0x)*(v2y-v0y) - (v1y-v0y)*(v2x-v0x)) >>> FRAC using a single
//   shared multiplier, then either clamps or wraps the result to OUT_W bits.
//   Orientation (negative) and degenerate (zero) flags are derived from the
//   final area so the cull stage sees exactly what the setup stage sees.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous abort of any in-flight or held result
//   in_valid   vertex set valid          in_ready  unit idle, can accept
//   in_tag     sideband tag, carried through unchanged to out_tag
//   v0x..v2y   signed fixed-point vertex coordinates
//   out_valid  result valid              out_ready downstream accepts result
//   area       signed area result (clamped or wrapped)
//   area_neg   area < 0 (clockwise / backface)
//   area_zero  area == 0 (degenerate)
//   area_sat   clamping occurred (never set when SAT=0)
//   out_tag    tag of the presented result
module edge_area_unit #(
  parameter int W     = 16,
  parameter int FRAC  = 6,
  parameter int OUT_W = 16,
  parameter int SAT   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     v0x,
  input  logic [W-1:0]     v0y,
  input  logic [W-1:0]     v1x,
  input  logic [W-1:0]     v1y,
  input  logic [W-1:0]     v2x,
  input  logic [W-1:0]     v2y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] area,
  output logic             area_neg,
  output logic             area_zero,
  output logic             area_sat,
  output logic [TAG_W-1:0] out_tag
);

  // Differences need one extra bit, products twice that, the sum one more.
  localparam int DW = W + 1;
  localparam int PW = 2 * W + 2;
  localparam int SW = 2 * W + 3;

  // Clamp bounds expressed at the sum width so the compare is exact.
  localparam logic signed [SW-1:0] MAX_C = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_C = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIFF = 3'd1,
    MUL0 = 3'd2,
    MUL1 = 3'd3,
    SUM  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t                  state_r;
  logic signed [W-1:0]     v0x_r, v0y_r, v1x_r, v1y_r, v2x_r, v2y_r;
  logic [TAG_W-1:0]        tag_r;
  logic signed [DW-1:0]    d0_r, d1_r, d2_r, d3_r;
  logic signed [PW-1:0]    m0_r, m1_r;
  logic [OUT_W-1:0]        area_r;
  logic                    neg_r, zero_r, sat_r, out_valid_r;
  logic [TAG_W-1:0]        out_tag_r;

  logic signed [DW-1:0]    mul_a_s, mul_b_s;
  logic signed [PW-1:0]    mul_p_s;
  logic signed [SW-1:0]    sum_s, shr_s;
  logic [OUT_W-1:0]        area_nxt_s;
  logic                    sat_nxt_s;

  // in_ready is gated by rst so it reads low while the unit is held in reset.
  assign in_ready  = rst & (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign area      = area_r;
  assign area_neg  = neg_r;
  assign area_zero = zero_r;
  assign area_sat  = sat_r;
  assign out_tag   = out_tag_r;

  // Shared multiplier operand select: first product in MUL0, second in MUL1.
  always_comb begin
    mul_a_s = {DW{1'b0}};
    mul_b_s = {DW{1'b0}};
    case (state_r)
      MUL0: begin
        mul_a_s = d0_r;
        mul_b_s = d1_r;
      end
      MUL1: begin
        mul_a_s = d2_r;
        mul_b_s = d3_r;
      end
      default: begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {DW{1'b0}};
      end
    endcase
  end

  assign mul_p_s = PW'(mul_a_s) * PW'(mul_b_s);
  assign sum_s   = SW'(m0_r) - SW'(m1_r);
  assign shr_s   = sum_s >>> FRAC;   // arithmetic shift: floor toward -inf

  // Final result formatting: clamp to the signed OUT_W range or wrap.
  always_comb begin
    area_nxt_s = shr_s[OUT_W-1:0];
    sat_nxt_s  = 1'b0;
    if (SAT != 0) begin
      if (shr_s > MAX_C) begin
        area_nxt_s = MAX_C[OUT_W-1:0];
        sat_nxt_s  = 1'b1;
      end else if (shr_s < MIN_C) begin
        area_nxt_s = MIN_C[OUT_W-1:0];
        sat_nxt_s  = 1'b1;
      end else begin
        area_nxt_s = shr_s[OUT_W-1:0];
        sat_nxt_s  = 1'b0;
      end
    end else begin
      area_nxt_s = shr_s[OUT_W-1:0];
      sat_nxt_s  = 1'b0;
    end
  end

  // Control FSM and datapath registers; flush acts as the synchronous abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      v0x_r       <= {W{1'b0}};
      v0y_r       <= {W{1'b0}};
      v1x_r       <= {W{1'b0}};
      v1y_r       <= {W{1'b0}};
      v2x_r       <= {W{1'b0}};
      v2y_r       <= {W{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      d0_r        <= {DW{1'b0}};
      d1_r        <= {DW{1'b0}};
      d2_r        <= {DW{1'b0}};
      d3_r        <= {DW{1'b0}};
      m0_r        <= {PW{1'b0}};
      m1_r        <= {PW{1'b0}};
      area_r      <= {OUT_W{1'b0}};
      neg_r       <= 1'b0;
      zero_r      <= 1'b0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      // area and out_tag deliberately keep their last value.
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      neg_r       <= 1'b0;
      zero_r      <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            v0x_r   <= v0x;
            v0y_r   <= v0y;
            v1x_r   <= v1x;
            v1y_r   <= v1y;
            v2x_r   <= v2x;
            v2y_r   <= v2y;
            tag_r   <= in_tag;
            state_r <= DIFF;
          end else begin
            state_r <= IDLE;
          end
        end
        DIFF: begin
          d0_r    <= DW'(v1x_r) - DW'(v0x_r);
          d1_r    <= DW'(v2y_r) - DW'(v0y_r);
          d2_r    <= DW'(v1y_r) - DW'(v0y_r);
          d3_r    <= DW'(v2x_r) - DW'(v0x_r);
          state_r <= MUL0;
        end
        MUL0: begin
          m0_r    <= mul_p_s;
          state_r <= MUL1;
        end
        MUL1: begin
          m1_r    <= mul_p_s;
          state_r <= SUM;
        end
        SUM: begin
          area_r      <= area_nxt_s;
          neg_r       <= area_nxt_s[OUT_W-1];
          zero_r      <= (area_nxt_s == {OUT_W{1'b0}});
          sat_r       <= sat_nxt_s;
          out_tag_r   <= tag_r;
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= OUT;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_area_unit.sv
module tb_edge_area_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [3:0]  in_tag;
  logic [15:0] v0x, v0y, v1x, v1y, v2x, v2y;

  logic        in_ready1, out_valid1, neg1, zero1, sat1;
  logic [15:0] area1;
  logic [3:0]  tag1;
  logic        in_ready0, out_valid0, neg0, zero0, sat0;
  logic [15:0] area0;
  logic [3:0]  tag0;

  edge_area_unit #(.W(16), .FRAC(6), .OUT_W(16), .SAT(1), .TAG_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_tag(in_tag), .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .out_valid(out_valid1), .out_ready(out_ready), .area(area1), .area_neg(neg1),
    .area_zero(zero1), .area_sat(sat1), .out_tag(tag1));

  edge_area_unit #(.W(16), .FRAC(6), .OUT_W(16), .SAT(0), .TAG_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_tag(in_tag), .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .out_valid(out_valid0), .out_ready(out_ready), .area(area0), .area_neg(neg0),
    .area_zero(zero0), .area_sat(sat0), .out_tag(tag0));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] area;
    logic        sat;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  typedef struct {
    int v0x, v0y, v1x, v1y, v2x, v2y;
    int tag;
    int a1;   // expected area, clamping build
    int s1;   // expected sat flag, clamping build
    int a0;   // expected area, wrapping build
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{0, 0, 640, 0, 0, 640, 5, 6400, 0, 6400};                         // basic
    vt[1] = '{0, 0, 64, 64, 128, 128, 7, 0, 0, 0};                             // degenerate
    vt[2] = '{0, 0, 1, 0, 0, -1, 8, -1, 0, -1};                                // floor
    vt[3] = '{-32768, -32768, 32767, -32768, -32768, 32767, 9, 32767, 1, -2048};  // +sat
    vt[4] = '{-32768, -32768, -32768, 32767, 32767, -32768, 12, -32768, 1, 2047}; // -sat
    vt[5] = '{10, 3, 20, 7, 5, 30, 11, 4, 0, 4};                               // 290>>>6
    vt[6] = '{64, 64, 192, 64, 64, 320, 10, 512, 0, 512};                      // offset origin
    vt[7] = '{0, 0, 0, 640, 640, 0, 6, -6400, 0, -6400};                       // swapped
  end

  // Scoreboard monitor for the clamping build: latency, hold stability, results.
  logic        pv, pr, pneg, pzero, psat;
  logic [15:0] parea;
  logic [3:0]  ptag;
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (out_valid1 && !pv) begin
        if (q1.size() == 0) chk("unexpected_valid_sat", 1, 0);
        else chk("latency", cyc - q1[0].acc, 4);
      end
      if (pv && !pr) begin
        chk("hold_valid", out_valid1, 1);
        chk("hold_area", area1, parea);
        chk("hold_tag", tag1, ptag);
        chk("hold_flags", {neg1, zero1, sat1}, {pneg, pzero, psat});
      end
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_result_sat", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("area_sat", area1, e.area);
          chk("tag_sat", tag1, e.tag);
          chk("satflag_sat", sat1, e.sat);
          chk("neg_sat", neg1, e.area[15]);
          chk("zero_sat", zero1, (e.area == 16'd0));
        end
      end
      pv = out_valid1; pr = out_ready; parea = area1; ptag = tag1;
      pneg = neg1; pzero = zero1; psat = sat1;
    end
  end

  // Scoreboard monitor for the wrapping build.
  always @(negedge clk) begin
    if (rst && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        chk("unexpected_result_wrap", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("area_wrap", area0, e.area);
        chk("tag_wrap", tag0, e.tag);
        chk("satflag_wrap", sat0, 0);
        chk("neg_wrap", neg0, e.area[15]);
        chk("zero_wrap", zero0, (e.area == 16'd0));
      end
    end
  end

  // Present vector i until accepted; optionally expect it to complete.
  task automatic send(input int i, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready1) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    v0x = 16'(vt[i].v0x); v0y = 16'(vt[i].v0y);
    v1x = 16'(vt[i].v1x); v1y = 16'(vt[i].v1y);
    v2x = 16'(vt[i].v2x); v2y = 16'(vt[i].v2y);
    in_tag = 4'(vt[i].tag);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.acc = cyc; e.tag = 4'(vt[i].tag);
      e.area = 16'(vt[i].a1); e.sat = vt[i].s1[0];
      q1.push_back(e);
      e.area = 16'(vt[i].a0); e.sat = 1'b0;
      q0.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0 || !in_ready1) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (q1.size() == 0 && q0.size() == 0 && in_ready1), 1);
  endtask

  initial begin
    int n;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_tag = 4'd0;
    v0x = 16'd0; v0y = 16'd0; v1x = 16'd0; v1y = 16'd0; v2x = 16'd0; v2y = 16'd0;
    #12;
    chk("rst_in_ready", in_ready1, 0);
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_area", area1, 0);
    chk("rst_flags", {neg1, zero1, sat1}, 0);
    chk("rst_tag", tag1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready1, 1);
    out_ready = 1'b1;

    // Basic case with in_ready timing.
    send(0, 1'b1);
    chk("busy_ready_0", in_ready1, 0);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      chk("busy_ready", in_ready1, 0);
    end
    @(posedge clk); #1;
    chk("ready_back", in_ready1, 1);

    // Backpressure: hold the result 3 cycles while new input is offered.
    out_ready = 1'b0;
    send(0, 1'b1);
    v0x = 16'd0; v0y = 16'd0; v1x = 16'd100; v1y = 16'd0; v2x = 16'd0; v2y = 16'd100;
    in_tag = 4'd15;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", out_valid1, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_ready_low", in_ready1, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", in_ready1, 1);
    chk("bp_idle_valid", out_valid1, 0);

    // Remaining directed vectors, back to back; ends with the swapped case.
    for (int i = 1; i < 8; i++) send(i, 1'b1);
    drain();

    // Flush while in MUL0.
    send(0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", in_ready1, 1);
    chk("flush_valid", out_valid1, 0);
    chk("flush_neg", neg1, 0);
    chk("flush_area_held", area1, 16'hE700);
    repeat (6) begin
      @(posedge clk); #1;
      chk("flush_no_valid", out_valid1, 0);
    end

    // Asynchronous reset while in MUL1.
    send(0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid1, 0);
    chk("arst_ready", in_ready1, 0);
    chk("arst_area", area1, 0);
    chk("arst_flags", {neg1, zero1, sat1}, 0);
    chk("arst_tag", tag1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("arst_no_valid", out_valid1, 0);
    end

    // Normal operation resumes after reset.
    send(2, 1'b1);
    send(3, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
